// File: rtl/banco_registros_param.sv
// Multiplier state register bank with a small result queue fed on rising done.
// Latency: state outputs 1 cycle after a load edge; pushed result visible 1 cycle after push.
// Backpressure: res_ready=0 holds the queue; pushes into a full queue without a pop are dropped.
// Optional feature: define REGMULT_OVF_FLAG_EN to enable the sticky overflow flag.
module banco_registros_param #(
    parameter int RES_W  = 16,
    parameter int TEMP_W = 2,
    parameter int CNT_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [RES_W-1:0]      sig_resultado,
    input  logic                         sig_done,
    input  logic                         sig_estado,
    input  logic        [TEMP_W-1:0]     sig_temp,
    input  logic        [CNT_W-1:0]      sig_contador,
    output logic signed [RES_W-1:0]      resultado,
    output logic                         done,
    output logic                         estado_actual,
    output logic        [TEMP_W-1:0]     temp,
    output logic        [CNT_W-1:0]      contador,
    output logic signed [RES_W-1:0]      res_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(DEPTH):0]       ocupacion,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic signed [RES_W-1:0]  resultado_q, resultado_d;
    logic                     done_q, done_d;
    logic                     estado_q, estado_d;
    logic        [TEMP_W-1:0] temp_q, temp_d;
    logic        [CNT_W-1:0]  contador_q, contador_d;

    logic signed [RES_W-1:0]  mem_q [DEPTH];
    logic        [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic        [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic        [OCC_W-1:0]  occ_q, occ_d;

    logic push, pop, full, wr_en;

    // Next state of the register bank: clear wins over load, otherwise hold.
    always_comb begin
        resultado_d = resultado_q;
        done_d      = done_q;
        estado_d    = estado_q;
        temp_d      = temp_q;
        contador_d  = contador_q;
        if (clr) begin
            resultado_d = '0;
            done_d      = 1'b0;
            estado_d    = 1'b0;
            temp_d      = '0;
            contador_d  = '0;
        end else if (en) begin
            resultado_d = sig_resultado;
            done_d      = sig_done;
            estado_d    = sig_estado;
            temp_d      = sig_temp;
            contador_d  = sig_contador;
        end
    end

    // Queue control: push on a rising done that is actually being loaded.
    // When full, a push is only accepted if the head leaves on the same edge;
    // the write slot then equals the slot being popped, which is safe.
    always_comb begin
        push     = en & ~clr & sig_done & ~done_q;
        pop      = (occ_q != '0) & res_ready;
        full     = (occ_q == OCC_W'(DEPTH));
        wr_en    = push & (~full | pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State and queue bookkeeping registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado_q <= '0;
            done_q      <= 1'b0;
            estado_q    <= 1'b0;
            temp_q      <= '0;
            contador_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            resultado_q <= resultado_d;
            done_q      <= done_d;
            estado_q    <= estado_d;
            temp_q      <= temp_d;
            contador_q  <= contador_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Queue storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sig_resultado;
        end
    end

`ifdef REGMULT_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky flag: set by any dropped push, cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | (push & full & ~pop);
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign resultado     = resultado_q;
    assign done          = done_q;
    assign estado_actual = estado_q;
    assign temp          = temp_q;
    assign contador      = contador_q;
    assign ocupacion     = occ_q;
    assign res_valid     = (occ_q != '0);
    assign res_out       = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
